regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port between the pipeline write-back stage (WB) and the

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_wr_fifo.sv | 109 ++++++++++
 rtl/regfile_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file write arbiter.
// RF_DATA_W / RF_ADDR_W are the default values of the DATA_W / ADDR_W parameters.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  // One register-file write request at the default widths.
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] dat;
  } wr_req_t;

  typedef enum logic {
    ARB_RUN   = 1'b0,
    ARB_STALL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Holding FIFO for multiply/divide results waiting for the register-file write port.
// Each entry carries a valid bit that a matching WB write clears (kill), so a stale
// MD result never overwrites a newer WB value. Optional kill count output under
// WRITE_ARB_STATS_EN.
module regfile_wr_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned KW    = $clog2(DEPTH + 2)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_reg_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  input  logic              kill_en_i,
  input  logic [ADDR_W-1:0] kill_reg_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              head_live_o,
  output logic [ADDR_W-1:0] head_reg_o,
  output logic [DATA_W-1:0] head_dat_o
`ifdef WRITE_ARB_STATS_EN
  ,
  output logic [KW-1:0]     kill_cnt_o
`endif
);

  logic [DEPTH-1:0]  used_q, used_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] reg_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0]  match;
  logic              push, pop, push_live;

  // Entries are contiguous from rd_ptr, so the write slot is occupied only when full.
  assign empty_o   = ~used_q[rd_ptr_q];
  assign full_o    = used_q[wr_ptr_q];
  assign push      = push_i & ~full_o;
  assign pop       = pop_i & ~empty_o;
  assign push_live = ~(kill_en_i && (push_reg_i == kill_reg_i));

  // Kill-match against every stored destination register.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = kill_en_i && (reg_q[i] == kill_reg_i);
    end
  end

  // A head killed this cycle is reported dead so it pops without using the port.
  assign head_live_o = used_q[rd_ptr_q] & vld_q[rd_ptr_q] & ~match[rd_ptr_q];
  assign head_reg_o  = reg_q[rd_ptr_q];
  assign head_dat_o  = dat_q[rd_ptr_q];

  // Next occupancy / valid bits: kill, then pop, then push into the free slot.
  always_comb begin
    used_d = used_q;
    vld_d  = vld_q & ~match;
    if (pop) begin
      used_d[rd_ptr_q] = 1'b0;
      vld_d[rd_ptr_q]  = 1'b0;
    end
    if (push) begin
      used_d[wr_ptr_q] = 1'b1;
      vld_d[wr_ptr_q]  = push_live;
    end
  end

`ifdef WRITE_ARB_STATS_EN
  // Entries newly killed this cycle, including a push killed on arrival.
  always_comb begin
    kill_cnt_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (used_q[i] && vld_q[i] && match[i]) kill_cnt_o = kill_cnt_o + 1'b1;
    end
    if (push && !push_live) kill_cnt_o = kill_cnt_o + 1'b1;
  end
`endif

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      used_q   <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      used_q <= used_d;
      vld_q  <= vld_d;
      if (push) begin
        reg_q[wr_ptr_q] <= push_reg_i;
        dat_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB (always wins) and buffered MD results.
// An MD head blocked for MAX_WAIT cycles raises Stall_Req until it drains.
// Optional statistics outputs (Stat_Blocked, Stat_Kills) when WRITE_ARB_STATS_EN is defined.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = RF_DATA_W,
  parameter int unsigned ADDR_W     = RF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Wb_Valid,
  input  logic [ADDR_W-1:0] Wb_Reg,
  input  logic [DATA_W-1:0] Wb_Dat,
  input  logic              Md_Valid,
  output logic              Md_Ready,
  input  logic [ADDR_W-1:0] Md_Reg,
  input  logic [DATA_W-1:0] Md_Dat,
  output logic              Stall_Req,
  output logic              Reg_Write,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Dat
`ifdef WRITE_ARB_STATS_EN
  ,
  output logic [15:0]       Stat_Blocked,
  output logic [7:0]        Stat_Kills
`endif
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned KW = $clog2(FIFO_DEPTH + 2);

  logic              fifo_full, fifo_empty, head_live;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_dat;
  logic              md_push, md_grant, pop, blocked;
  logic [WW-1:0]     wait_q, wait_d;
  arb_state_e        state_q, state_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_dat_q, write_dat_d;

  assign Md_Ready = ~fifo_full;
  assign md_push  = Md_Valid & ~fifo_full;
  // A dead (killed) head pops immediately; a live head pops only when WB is idle.
  assign md_grant = ~Wb_Valid & head_live;
  assign pop      = ~fifo_empty & (~head_live | ~Wb_Valid);
  assign blocked  = Wb_Valid & head_live;

`ifdef WRITE_ARB_STATS_EN
  logic [KW-1:0] kill_cnt;
`endif

  regfile_wr_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (Clk),
    .rst_ni      (Rst_n),
    .push_i      (md_push),
    .push_reg_i  (Md_Reg),
    .push_dat_i  (Md_Dat),
    .pop_i       (pop),
    .kill_en_i   (Wb_Valid),
    .kill_reg_i  (Wb_Reg),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_live_o (head_live),
    .head_reg_o  (head_reg),
    .head_dat_o  (head_dat)
`ifdef WRITE_ARB_STATS_EN
    ,
    .kill_cnt_o  (kill_cnt)
`endif
  );

  // Wait counter: cycles the live head loses to WB, saturating at MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (fifo_empty || pop) wait_d = '0;
    else if (blocked && (wait_q < WW'(MAX_WAIT))) wait_d = wait_q + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ARB_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // FSM next state; uses the updated count so the stall starts right after the last blocked cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN:   if (wait_d == WW'(MAX_WAIT)) state_d = ARB_STALL;
      ARB_STALL: if (pop) state_d = ARB_RUN;
      default:   state_d = ARB_RUN;
    endcase
  end

  // FSM output.
  always_comb begin
    Stall_Req = (state_q == ARB_STALL);
  end

  // Write-port selection; register 0 consumes the slot without enabling the write.
  always_comb begin
    reg_write_d = 1'b0;
    write_reg_d = write_reg_q;
    write_dat_d = write_dat_q;
    if (Wb_Valid) begin
      reg_write_d = (Wb_Reg != '0);
      write_reg_d = Wb_Reg;
      write_dat_d = Wb_Dat;
    end else if (md_grant) begin
      reg_write_d = (head_reg != '0);
      write_reg_d = head_reg;
      write_dat_d = head_dat;
    end
  end

  // Registered write port.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      write_dat_q <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      write_dat_q <= write_dat_d;
    end
  end

  assign Reg_Write = reg_write_q;
  assign Write_Reg = write_reg_q;
  assign Write_Dat = write_dat_q;

`ifdef WRITE_ARB_STATS_EN
  logic [15:0] stat_blocked_q;
  logic [7:0]  stat_kills_q;
  logic [8:0]  kills_sum;

  assign kills_sum = {1'b0, stat_kills_q} + 9'(kill_cnt);

  // Saturating statistics counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stat_blocked_q <= '0;
      stat_kills_q   <= '0;
    end else begin
      if (!fifo_empty && Wb_Valid && (stat_blocked_q != '1)) stat_blocked_q <= stat_blocked_q + 1'b1;
      stat_kills_q <= kills_sum[8] ? '1 : kills_sum[7:0];
    end
  end

  assign Stat_Blocked = stat_blocked_q;
  assign Stat_Kills   = stat_kills_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default build).
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic        Clk, Rst_n;
  logic        Wb_Valid, Md_Valid, Md_Ready, Stall_Req, Reg_Write;
  logic [4:0]  Wb_Reg, Md_Reg, Write_Reg;
  logic [31:0] Wb_Dat, Md_Dat, Write_Dat;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .FIFO_DEPTH (2),
    .MAX_WAIT   (4)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Wb_Valid  (Wb_Valid),
    .Wb_Reg    (Wb_Reg),
    .Wb_Dat    (Wb_Dat),
    .Md_Valid  (Md_Valid),
    .Md_Ready  (Md_Ready),
    .Md_Reg    (Md_Reg),
    .Md_Dat    (Md_Dat),
    .Stall_Req (Stall_Req),
    .Reg_Write (Reg_Write),
    .Write_Reg (Write_Reg),
    .Write_Dat (Write_Dat)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Wb_Valid = 1'b0; Wb_Reg = '0; Wb_Dat = '0;
    Md_Valid = 1'b0; Md_Reg = '0; Md_Dat = '0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reset.we got=%0b exp=0", Reg_Write); end
    n_checks++; if (Write_Reg !== 5'd0) begin n_fail++; $display("FAIL reset.reg got=%0d exp=0", Write_Reg); end
    n_checks++; if (Write_Dat !== 32'd0) begin n_fail++; $display("FAIL reset.dat got=%h exp=0", Write_Dat); end
    n_checks++; if (Stall_Req !== 1'b0) begin n_fail++; $display("FAIL reset.stall got=%0b exp=0", Stall_Req); end
    n_checks++; if (Md_Ready !== 1'b1) begin n_fail++; $display("FAIL reset.ready got=%0b exp=1", Md_Ready); end
    Rst_n = 1'b1;
    tick();
    // Queue two MD entries behind WB traffic, then reset mid-stream.
    Wb_Valid = 1'b1; Wb_Reg = 5'd1; Wb_Dat = 32'h1;
    Md_Valid = 1'b1; Md_Reg = 5'd2; Md_Dat = 32'h22;
    tick();
    Md_Reg = 5'd3; Md_Dat = 32'h33;
    tick();
    Md_Valid = 1'b0;
    n_checks++; if (Md_Ready !== 1'b0) begin n_fail++; $display("FAIL reset.queued_full got=%0b exp=0", Md_Ready); end
    n_checks++; if (Reg_Write !== 1'b1) begin n_fail++; $display("FAIL reset.pre_we got=%0b exp=1", Reg_Write); end
    Rst_n = 1'b0;
    #1;
    n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reset.async_we got=%0b exp=0", Reg_Write); end
    n_checks++; if (Write_Reg !== 5'd0) begin n_fail++; $display("FAIL reset.async_reg got=%0d exp=0", Write_Reg); end
    n_checks++; if (Write_Dat !== 32'd0) begin n_fail++; $display("FAIL reset.async_dat got=%h exp=0", Write_Dat); end
    n_checks++; if (Md_Ready !== 1'b1) begin n_fail++; $display("FAIL reset.async_ready got=%0b exp=1", Md_Ready); end
    idle_inputs();
    tick();
    Rst_n = 1'b1;
    // Discarded entries must never drain to the port.
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reset.drain%0d got=%0b exp=0", c, Reg_Write); end
    end
  endtask

  task automatic test_wb_only();
    Wb_Valid = 1'b1; Wb_Reg = 5'd5; Wb_Dat = 32'hDEADBEEF;
    tick();
    Wb_Valid = 1'b0;
    n_checks++; if (Reg_Write !== 1'b1) begin n_fail++; $display("FAIL wb.we got=%0b exp=1", Reg_Write); end
    n_checks++; if (Write_Reg !== 5'd5) begin n_fail++; $display("FAIL wb.reg got=%0d exp=5", Write_Reg); end
    n_checks++; if (Write_Dat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb.dat got=%h exp=deadbeef", Write_Dat); end
    tick();
    n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL wb.idle got=%0b exp=0", Reg_Write); end
  endtask

  task automatic test_contention();
    wr_req_t exp;
    logic    exp_stall;
    for (int c = 0; c < 5; c++) begin
      Wb_Valid = 1'b1; Wb_Reg = 5'(10 + c); Wb_Dat = 32'(32'h100 + c);
      Md_Valid = (c == 0); Md_Reg = 5'd7; Md_Dat = 32'h11;
      tick();
      // Entry lands after cycle 0; cycles 1..4 block it; stall visible after the 4th.
      exp_stall = (c == 4);
      n_checks++; if (Write_Reg !== 5'(10 + c)) begin n_fail++; $display("FAIL cont.wb_reg%0d got=%0d exp=%0d", c, Write_Reg, 10 + c); end
      n_checks++; if (Stall_Req !== exp_stall) begin n_fail++; $display("FAIL cont.stall%0d got=%0b exp=%0b", c, Stall_Req, exp_stall); end
    end
    idle_inputs();
    tick();
    exp = '{valid: 1'b1, addr: 5'd7, dat: 32'h11};
    n_checks++; if (Reg_Write !== exp.valid) begin n_fail++; $display("FAIL cont.md_we got=%0b exp=%0b", Reg_Write, exp.valid); end
    n_checks++; if (Write_Reg !== exp.addr) begin n_fail++; $display("FAIL cont.md_reg got=%0d exp=%0d", Write_Reg, exp.addr); end
    n_checks++; if (Write_Dat !== exp.dat) begin n_fail++; $display("FAIL cont.md_dat got=%h exp=%h", Write_Dat, exp.dat); end
    n_checks++; if (Stall_Req !== 1'b0) begin n_fail++; $display("FAIL cont.unstall got=%0b exp=0", Stall_Req); end
    tick();
    n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL cont.idle got=%0b exp=0", Reg_Write); end
  endtask

  task automatic test_full();
    wr_req_t exp_q [3];
    exp_q[0] = '{valid: 1'b1, addr: 5'd11, dat: 32'hA1};
    exp_q[1] = '{valid: 1'b1, addr: 5'd12, dat: 32'hA2};
    exp_q[2] = '{valid: 1'b1, addr: 5'd13, dat: 32'hA3};
    for (int c = 0; c < 3; c++) begin
      Wb_Valid = 1'b1; Wb_Reg = 5'(20 + c); Wb_Dat = 32'(c);
      Md_Valid = 1'b1; Md_Reg = exp_q[c].addr; Md_Dat = exp_q[c].dat;
      tick();
      n_checks++; if (Md_Ready !== (c == 0)) begin n_fail++; $display("FAIL full.ready%0d got=%0b exp=%0b", c, Md_Ready, (c == 0)); end
    end
    // WB goes idle; the third MD result is still held on the MD side.
    Wb_Valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 1) Md_Valid = 1'b0;
      n_checks++; if (Reg_Write !== 1'b1) begin n_fail++; $display("FAIL full.we%0d got=%0b exp=1", c, Reg_Write); end
      n_checks++; if (Write_Reg !== exp_q[c].addr) begin n_fail++; $display("FAIL full.reg%0d got=%0d exp=%0d", c, Write_Reg, exp_q[c].addr); end
      n_checks++; if (Write_Dat !== exp_q[c].dat) begin n_fail++; $display("FAIL full.dat%0d got=%h exp=%h", c, Write_Dat, exp_q[c].dat); end
    end
    idle_inputs();
    tick();
    n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL full.idle got=%0b exp=0", Reg_Write); end
    n_checks++; if (Stall_Req !== 1'b0) begin n_fail++; $display("FAIL full.stall got=%0b exp=0", Stall_Req); end
  endtask

  task automatic test_kill();
    Wb_Valid = 1'b1; Wb_Reg = 5'd1; Wb_Dat = 32'h1;
    Md_Valid = 1'b1; Md_Reg = 5'd9; Md_Dat = 32'h99;
    tick();
    Md_Valid = 1'b0;
    Wb_Reg = 5'd9; Wb_Dat = 32'h5;
    tick();
    Wb_Valid = 1'b0;
    n_checks++; if (Write_Reg !== 5'd9 || Write_Dat !== 32'h5) begin n_fail++; $display("FAIL kill.wb got=%0d/%h exp=9/5", Write_Reg, Write_Dat); end
    n_checks++; if (Md_Ready !== 1'b1) begin n_fail++; $display("FAIL kill.ready got=%0b exp=1", Md_Ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL kill.dropped%0d got=%0b exp=0", c, Reg_Write); end
    end
    // Same-cycle push to the register WB is writing is killed on arrival.
    Wb_Valid = 1'b1; Wb_Reg = 5'd14; Wb_Dat = 32'h77;
    Md_Valid = 1'b1; Md_Reg = 5'd14; Md_Dat = 32'h88;
    tick();
    idle_inputs();
    n_checks++; if (Write_Dat !== 32'h77) begin n_fail++; $display("FAIL kill.same_wb got=%h exp=77", Write_Dat); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL kill.same_dropped%0d got=%0b exp=0", c, Reg_Write); end
    end
  endtask

  task automatic test_reg0();
    Wb_Valid = 1'b1; Wb_Reg = 5'd0; Wb_Dat = 32'h123;
    tick();
    n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reg0.wb got=%0b exp=0", Reg_Write); end
    // Fill the FIFO with two reg-0 MD entries behind WB reg 3.
    Wb_Reg = 5'd3; Wb_Dat = 32'h3;
    Md_Valid = 1'b1; Md_Reg = 5'd0; Md_Dat = 32'hF1;
    tick();
    Md_Dat = 32'hF2;
    tick();
    idle_inputs();
    n_checks++; if (Md_Ready !== 1'b0) begin n_fail++; $display("FAIL reg0.full got=%0b exp=0", Md_Ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reg0.md_we%0d got=%0b exp=0", c, Reg_Write); end
      n_checks++; if (Md_Ready !== 1'b1) begin n_fail++; $display("FAIL reg0.ready%0d got=%0b exp=1", c, Md_Ready); end
    end
    tick();
    n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reg0.empty got=%0b exp=0", Reg_Write); end
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_contention();
    test_full();
    test_kill();
    test_reg0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
